// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - aligned store FIFO draining to the data-memory write channel
// Stores enter with lane-replicated data and byte enables; loads to a pending word stall.
module store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [2:0]               st_funct3,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_hazard,
  input  logic                     dmem_grant,
  output logic                     dmem_write,
  output logic [31:0]              dmem_address,
  output logic [31:0]              dmem_wdata,
  output logic [3:0]               dmem_mbe,
  input  logic                     dmem_resp,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [0:0] STATE_IDLE  = 1'b0;
  localparam logic [0:0] STATE_WRITE = 1'b1;

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [0:0]    state, state_nxt;
  logic [29:0]   ent_addr [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [3:0]    ent_mbe  [DEPTH];

  logic          legal;
  logic [31:0]   al_data;
  logic [3:0]    al_mbe;
  logic          push, pop;

  always_comb begin
    legal   = 1'b1;
    al_data = st_data;
    al_mbe  = 4'b1111;
    case (st_funct3)
      3'b000: begin
        al_data = {4{st_data[7:0]}};
        al_mbe  = 4'b0001 << st_addr[1:0];
      end
      3'b001: begin
        al_data = {2{st_data[15:0]}};
        al_mbe  = 4'b0011 << {st_addr[1], 1'b0};
      end
      3'b010: begin
        al_data = st_data;
        al_mbe  = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

  assign st_ready = (count < FULL);
  assign push     = st_valid && st_ready && legal;
  assign pop      = (state == STATE_WRITE) && dmem_resp;

  // Continuing in WRITE only considers entries older than any same-cycle push,
  // so a fresh store always spends a cycle visible before it is written.
  always_comb begin
    state_nxt = state;
    case (state)
      STATE_IDLE:  if (count != '0 && dmem_grant) state_nxt = STATE_WRITE;
      STATE_WRITE: if (dmem_resp)
        state_nxt = (count > (PW+1)'(1) && dmem_grant) ? STATE_WRITE : STATE_IDLE;
      default:     state_nxt = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= STATE_IDLE;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (!push && pop) count <= count - (PW+1)'(1);
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr[31:2];
      ent_data[tail] <= al_data;
      ent_mbe[tail]  <= al_mbe;
    end
  end

  assign dmem_write   = (state == STATE_WRITE);
  assign dmem_address = dmem_write ? {ent_addr[head], 2'b00} : 32'h0;
  assign dmem_wdata   = dmem_write ? ent_data[head] : 32'h0;
  assign dmem_mbe     = dmem_write ? ent_mbe[head] : 4'h0;

  // An entry is occupied when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] off;
    ld_hazard = 1'b0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head;
      if ({1'b0, off} < count && ent_addr[i] == ld_addr[31:2]) ld_hazard = ld_valid;
    end
  end

  assign sb_empty = (count == '0);
  assign sb_count = count;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
// A negedge memory model answers writes after a set latency and logs them.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr, st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        dmem_grant, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp;
  logic        sb_empty;
  logic [1:0]  sb_count;

  store_buffer #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_funct3(st_funct3),
    .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .dmem_grant(dmem_grant), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_resp(dmem_resp),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr, data, ea, ed;
    logic [3:0]  em;
  } vec_t;
  typedef struct {
    logic [31:0] a, d;
    logic [3:0]  m;
  } wr_t;

  vec_t vecs [10];
  wr_t  log_q [$];
  int   checks = 0;
  int   errors = 0;
  logic auto_en = 1'b0;
  int   lat = 3;
  int   wcnt = 0;
  logic auto_resp = 1'b0;
  logic man_resp = 1'b0;
  assign dmem_resp = auto_resp | man_resp;

  initial begin
    forever begin
      @(negedge clk);
      if (!auto_en || rst) begin
        auto_resp = 1'b0;
        wcnt = 0;
      end else begin
        if (auto_resp) begin
          auto_resp = 1'b0;
          wcnt = 0;
        end
        if (dmem_write) begin
          wcnt++;
          if (wcnt == lat) begin
            auto_resp = 1'b1;
            log_q.push_back('{dmem_address, dmem_wdata, dmem_mbe});
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    st_valid  = 1'b1;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
  endtask

  task automatic count_run(output int n);
    n = 0;
    while (dmem_write && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_write"}, 32'(dmem_write), 0);
    chk({tag, "_addr"}, dmem_address, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_mbe"}, 32'(dmem_mbe), 0);
    chk({tag, "_ready"}, 32'(st_ready), 1);
    chk({tag, "_empty"}, 32'(sb_empty), 1);
    chk({tag, "_count"}, 32'(sb_count), 0);
    chk({tag, "_hazard"}, 32'(ld_hazard), 0);
  endtask

  initial begin
    int n;
    int pushed;
    vecs[0] = '{3'b000, 32'h4000, 32'h11,       32'h4000, 32'h11111111, 4'b0001};
    vecs[1] = '{3'b000, 32'h4001, 32'hFFFFFF22, 32'h4000, 32'h22222222, 4'b0010};
    vecs[2] = '{3'b000, 32'h4002, 32'h33,       32'h4000, 32'h33333333, 4'b0100};
    vecs[3] = '{3'b000, 32'h4007, 32'h44,       32'h4004, 32'h44444444, 4'b1000};
    vecs[4] = '{3'b001, 32'h4008, 32'hAAAA5566, 32'h4008, 32'h55665566, 4'b0011};
    vecs[5] = '{3'b001, 32'h400B, 32'h7788,     32'h4008, 32'h77887788, 4'b1100};
    vecs[6] = '{3'b010, 32'h400F, 32'hDEADBEEF, 32'h400C, 32'hDEADBEEF, 4'b1111};
    vecs[7] = '{3'b010, 32'h4010, 32'h01234567, 32'h4010, 32'h01234567, 4'b1111};
    vecs[8] = '{3'b001, 32'h4011, 32'h9ABC,     32'h4010, 32'h9ABC9ABC, 4'b0011};
    vecs[9] = '{3'b000, 32'h4016, 32'h5A,       32'h4014, 32'h5A5A5A5A, 4'b0100};

    rst = 1'b1; st_valid = 1'b0; st_funct3 = 3'b0; st_addr = 0; st_data = 0;
    ld_valid = 1'b0; ld_addr = 0; dmem_grant = 1'b0;
    #2;
    check_idle_outputs("reset");
    tick(); tick();
    rst = 1'b0;

    // single sb
    auto_en = 1'b1; lat = 3; dmem_grant = 1'b1; log_q.delete();
    tick(); store(3'b000, 32'h0100_0003, 32'hA5);
    tick(); st_valid = 1'b0;
    @(negedge clk);
    chk("sb_count_after_enq", 32'(sb_count), 1);
    chk("sb_no_early_write", 32'(dmem_write), 0);
    tick(); @(negedge clk);
    chk("sb_write", 32'(dmem_write), 1);
    chk("sb_addr", dmem_address, 32'h0100_0000);
    chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk("sb_mbe", 32'(dmem_mbe), 32'b1000);
    count_run(n);
    chk("sb_write_cycles", n, 3);
    chk("sb_empty_after", 32'(sb_empty), 1);

    // sh then sw, back to back
    log_q.delete();
    tick(); store(3'b001, 32'h2002, 32'h1234BEEF);
    tick(); store(3'b010, 32'h2004, 32'hCAFEF00D);
    tick(); st_valid = 1'b0;
    @(negedge clk);
    chk("sh_write", 32'(dmem_write), 1);
    chk("sh_addr", dmem_address, 32'h2000);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_mbe", 32'(dmem_mbe), 32'b1100);
    count_run(n);
    chk("shsw_no_bubble_run", n, 6);
    chk("shsw_log_size", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("sw_addr", log_q[1].a, 32'h2004);
      chk("sw_wdata", log_q[1].d, 32'hCAFEF00D);
      chk("sw_mbe", 32'(log_q[1].m), 32'b1111);
    end

    // full buffer, manual responses
    auto_en = 1'b0; dmem_grant = 1'b0;
    tick(); store(3'b010, 32'h10, 32'h1);
    @(negedge clk); chk("full_ready0", 32'(st_ready), 1);
    tick(); store(3'b010, 32'h14, 32'h2);
    @(negedge clk); chk("full_ready1", 32'(st_ready), 1);
    tick(); store(3'b010, 32'h18, 32'h3);
    @(negedge clk);
    chk("full_ready2", 32'(st_ready), 0);
    chk("full_count", 32'(sb_count), 2);
    tick(); st_valid = 1'b0; dmem_grant = 1'b1;
    @(negedge clk); chk("full_count_hold", 32'(sb_count), 2);
    tick(); @(negedge clk);
    chk("full_first_addr", dmem_address, 32'h10);
    tick(); man_resp = 1'b1;
    @(negedge clk); chk("full_ready_resp_cycle", 32'(st_ready), 0);
    tick(); man_resp = 1'b0;
    @(negedge clk);
    chk("full_ready_after", 32'(st_ready), 1);
    chk("full_count_after", 32'(sb_count), 1);
    chk("full_second_write", 32'(dmem_write), 1);
    chk("full_second_addr", dmem_address, 32'h14);
    tick(); man_resp = 1'b1;
    tick(); man_resp = 1'b0;
    @(negedge clk);
    chk("full_drained", 32'(sb_count), 0);
    chk("full_drained_write", 32'(dmem_write), 0);

    // load hazard
    auto_en = 1'b1; lat = 3; dmem_grant = 1'b0;
    tick(); store(3'b010, 32'h3000, 32'h77);
    tick(); st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h3002;
    @(negedge clk);
    chk("haz_same_word", 32'(ld_hazard), 1);
    ld_addr = 32'h3004; #1;
    chk("haz_other_word", 32'(ld_hazard), 0);
    ld_addr = 32'h3002;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) dmem_grant = 1'b1;
      @(negedge clk);
      chk($sformatf("haz_cycle%0d", k), 32'(ld_hazard), (k < 4) ? 1 : 0);
    end
    tick(); ld_valid = 1'b0;

    // reset mid-write
    auto_en = 1'b0; dmem_grant = 1'b0;
    tick(); store(3'b010, 32'h5000, 32'h5);
    tick(); store(3'b010, 32'h5004, 32'h6);
    tick(); st_valid = 1'b0; dmem_grant = 1'b1; ld_valid = 1'b1; ld_addr = 32'h5000;
    tick(); @(negedge clk);
    chk("rst_pre_write", 32'(dmem_write), 1);
    chk("rst_pre_count", 32'(sb_count), 2);
    chk("rst_pre_hazard", 32'(ld_hazard), 1);
    #1 rst = 1'b1;
    #1 check_idle_outputs("rst_mid");
    tick(); rst = 1'b0; ld_valid = 1'b0; dmem_grant = 1'b0; man_resp = 1'b1;
    tick(); man_resp = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_stray_resp");

    // illegal funct3
    tick(); store(3'b011, 32'h6000, 32'h9);
    tick(); st_valid = 1'b0;
    @(negedge clk);
    chk("illegal_count", 32'(sb_count), 0);

    // ten stores with pointer wrap
    auto_en = 1'b1; lat = 1; dmem_grant = 1'b1; log_q.delete();
    pushed = 0;
    for (int c = 0; c < 200 && pushed < 10; c++) begin
      tick();
      if (st_ready) begin
        store(vecs[pushed].f3, vecs[pushed].addr, vecs[pushed].data);
        pushed++;
      end else begin
        st_valid = 1'b0;
      end
    end
    tick(); st_valid = 1'b0;
    for (int c = 0; c < 300 && log_q.size() < 10; c++) @(negedge clk);
    chk("wrap_write_count", log_q.size(), 10);
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      chk($sformatf("wrap%0d_addr", i), log_q[i].a, vecs[i].ea);
      chk($sformatf("wrap%0d_wdata", i), log_q[i].d, vecs[i].ed);
      chk($sformatf("wrap%0d_mbe", i), 32'(log_q[i].m), 32'(vecs[i].em));
    end
    @(negedge clk);
    chk("wrap_empty", 32'(sb_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
